// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that lets several pixel producers share one vga_adapter port,
// with screen-bounds clipping and pixel/clip statistics.
module vga_plot_arbiter #(
    parameter int N_REQ = 3,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic               CLOCK_50,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   plot,
    input  logic [N_REQ*8-1:0] x_in,
    input  logic [N_REQ*7-1:0] y_in,
    input  logic [N_REQ*3-1:0] colour_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               VGA_PLOT,
    output logic [7:0]         VGA_X,
    output logic [6:0]         VGA_Y,
    output logic [2:0]         VGA_COLOUR,
    output logic               busy,
    output logic [15:0]        pix_count,
    output logic [7:0]         clip_count
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] rr_r;
    logic [IDX_W-1:0] rr_s;
    logic [IDX_W-1:0] gidx_r;
    logic [IDX_W-1:0] gidx_s;
    logic [IDX_W-1:0] sel_s;
    logic             found_s;
    logic [N_REQ-1:0] gnt_s;
    logic [7:0]       x_g_s;
    logic [6:0]       y_g_s;
    logic [2:0]       c_g_s;
    logic             pix_v_s;
    logic             clip_v_s;

    function automatic logic in_window(input logic [7:0] x, input logic [6:0] y);
        return (int'(x) < X_MAX) && (int'(y) < Y_MAX);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) >= N_REQ - 1) begin
            return {IDX_W{1'b0}};
        end else begin
            return i + 1'b1;
        end
    endfunction

    // Only the granted lane's coordinates ever reach the adapter.
    assign x_g_s = x_in[int'(gidx_r)*8 +: 8];
    assign y_g_s = y_in[int'(gidx_r)*7 +: 7];
    assign c_g_s = colour_in[int'(gidx_r)*3 +: 3];

    // First requesting index at or after the rotating pointer, wrapping modulo N_REQ.
    always_comb begin
        int cand;
        sel_s   = {IDX_W{1'b0}};
        found_s = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_r) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end else begin
                cand = cand;
            end
            if (!found_s && req[cand]) begin
                found_s = 1'b1;
                sel_s   = IDX_W'(cand);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state, grant and pixel-issue decode.
    always_comb begin
        state_s  = state_r;
        rr_s     = rr_r;
        gidx_s   = gidx_r;
        gnt_s    = gnt;
        pix_v_s  = 1'b0;
        clip_v_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s       = GRANTED;
                    gidx_s        = sel_s;
                    gnt_s         = {N_REQ{1'b0}};
                    gnt_s[sel_s]  = 1'b1;
                end else begin
                    gnt_s = {N_REQ{1'b0}};
                end
            end
            GRANTED: begin
                // A release wins over a simultaneous strobe, so that pixel is dropped.
                if (!req[gidx_r]) begin
                    state_s = GAP;
                    gnt_s   = {N_REQ{1'b0}};
                    rr_s    = next_idx(gidx_r);
                end else if (plot[gidx_r]) begin
                    if (in_window(x_g_s, y_g_s)) begin
                        pix_v_s = 1'b1;
                    end else begin
                        clip_v_s = 1'b1;
                    end
                end else begin
                    state_s = GRANTED;
                end
            end
            GAP: begin
                state_s = IDLE;
                gnt_s   = {N_REQ{1'b0}};
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {N_REQ{1'b0}};
            end
        endcase
    end

    // State, grant, adapter drive and statistics registers.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rr_r       <= {IDX_W{1'b0}};
            gidx_r     <= {IDX_W{1'b0}};
            gnt        <= {N_REQ{1'b0}};
            busy       <= 1'b0;
            VGA_PLOT   <= 1'b0;
            VGA_X      <= 8'd0;
            VGA_Y      <= 7'd0;
            VGA_COLOUR <= 3'd0;
            pix_count  <= 16'd0;
            clip_count <= 8'd0;
        end else begin
            state_r    <= state_s;
            rr_r       <= rr_s;
            gidx_r     <= gidx_s;
            gnt        <= gnt_s;
            busy       <= (state_s != IDLE);
            VGA_PLOT   <= pix_v_s;
            VGA_X      <= pix_v_s ? x_g_s : 8'd0;
            VGA_Y      <= pix_v_s ? y_g_s : 7'd0;
            VGA_COLOUR <= pix_v_s ? c_g_s : 3'd0;
            pix_count  <= pix_count + {15'd0, pix_v_s};
            if (clip_v_s && (clip_count != 8'hFF)) begin
                clip_count <= clip_count + 8'd1;
            end else begin
                clip_count <= clip_count;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed, table-driven bench for vga_plot_arbiter plus hand-written
// round-robin and clip-saturation sequences.
module tb_vga_plot_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  plot;
    logic [23:0] x_in;
    logic [20:0] y_in;
    logic [8:0]  colour_in;
    logic [2:0]  gnt;
    logic        VGA_PLOT;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [2:0]  VGA_COLOUR;
    logic        busy;
    logic [15:0] pix_count;
    logic [7:0]  clip_count;

    int n_cmp  = 0;
    int n_fail = 0;

    vga_plot_arbiter #(.N_REQ(3), .X_MAX(160), .Y_MAX(120)) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .req        (req),
        .plot       (plot),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .gnt        (gnt),
        .VGA_PLOT   (VGA_PLOT),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_COLOUR (VGA_COLOUR),
        .busy       (busy),
        .pix_count  (pix_count),
        .clip_count (clip_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       rst_n;
        logic [2:0] req;
        logic [2:0] plot;
        int         lane;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [2:0] e_gnt;
        logic       e_plot;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
        logic       e_busy;
        logic [15:0] e_pix;
        logic [7:0] e_clip;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic r, input logic [2:0] rq, input logic [2:0] pl,
                                input int lane, input logic [7:0] x, input logic [6:0] y,
                                input logic [2:0] c, input logic [2:0] eg, input logic ep,
                                input logic [7:0] ex, input logic [6:0] ey, input logic [2:0] ec,
                                input logic eb, input logic [15:0] epix, input logic [7:0] eclip);
        vec_t v;
        v.rst_n = r;  v.req = rq; v.plot = pl; v.lane = lane;
        v.x = x; v.y = y; v.c = c;
        v.e_gnt = eg; v.e_plot = ep; v.e_x = ex; v.e_y = ey; v.e_c = ec;
        v.e_busy = eb; v.e_pix = epix; v.e_clip = eclip;
        vt.push_back(v);
    endfunction

    // Non-selected lanes carry distinct in-range junk so a wrong lane select is visible.
    task automatic drive(input logic r, input logic [2:0] rq, input logic [2:0] pl,
                         input int lane, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c);
        rst_n = r;
        req   = rq;
        plot  = pl;
        for (int i = 0; i < 3; i++) begin
            if (i == lane) begin
                x_in[i*8 +: 8]      = x;
                y_in[i*7 +: 7]      = y;
                colour_in[i*3 +: 3] = c;
            end else begin
                x_in[i*8 +: 8]      = 8'(90 + i);
                y_in[i*7 +: 7]      = 7'(90 + i);
                colour_in[i*3 +: 3] = ~c;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    logic [2:0] req_h;
    logic [2:0] oh;

    initial begin
        drive(1'b0, 3'b000, 3'b000, 0, 8'd0, 7'd0, 3'd0);

        //  rst req    plot   ln x       y       c       gnt    vp  vx       vy       vc    busy pix    clip
        // reset idle
        add(0, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);
        add(0, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);
        // single burst of three pixels from requester 0
        add(1, 3'b001, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b001, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(1, 3'b001, 3'b001, 0, 8'd5,   7'd10,  3'd4, 3'b001, 1, 8'd5,   7'd10,  3'd4, 1, 16'd1, 8'd0);
        add(1, 3'b001, 3'b001, 0, 8'd6,   7'd10,  3'd4, 3'b001, 1, 8'd6,   7'd10,  3'd4, 1, 16'd2, 8'd0);
        add(1, 3'b001, 3'b001, 0, 8'd7,   7'd10,  3'd4, 3'b001, 1, 8'd7,   7'd10,  3'd4, 1, 16'd3, 8'd0);
        add(1, 3'b001, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b001, 0, 8'd0,   7'd0,   3'd0, 1, 16'd3, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 1, 16'd3, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd3, 8'd0);
        // clipping after a fresh reset
        add(0, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);
        add(1, 3'b001, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b001, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(1, 3'b001, 3'b001, 0, 8'd160, 7'd0,   3'd2, 3'b001, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd1);
        add(1, 3'b001, 3'b001, 0, 8'd0,   7'd120, 3'd2, 3'b001, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd2);
        add(1, 3'b001, 3'b001, 0, 8'd159, 7'd119, 3'd3, 3'b001, 1, 8'd159, 7'd119, 3'd3, 1, 16'd1, 8'd2);
        add(1, 3'b001, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b001, 0, 8'd0,   7'd0,   3'd0, 1, 16'd1, 8'd2);
        // non-granted strobe ignored, release with plot drops the pixel
        add(1, 3'b011, 3'b010, 1, 8'd20,  7'd20,  3'd1, 3'b001, 0, 8'd0,   7'd0,   3'd0, 1, 16'd1, 8'd2);
        add(1, 3'b010, 3'b001, 0, 8'd30,  7'd30,  3'd6, 3'b000, 0, 8'd0,   7'd0,   3'd0, 1, 16'd1, 8'd2);
        add(1, 3'b010, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd1, 8'd2);
        add(1, 3'b010, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b010, 0, 8'd0,   7'd0,   3'd0, 1, 16'd1, 8'd2);
        add(1, 3'b010, 3'b010, 1, 8'd40,  7'd50,  3'd5, 3'b010, 1, 8'd40,  7'd50,  3'd5, 1, 16'd2, 8'd2);
        // reset mid-burst with a plot in flight, then requester 2 alone
        add(0, 3'b010, 3'b010, 1, 8'd41,  7'd51,  3'd5, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);
        add(1, 3'b100, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b100, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);
        // pointer moves to 1, reset must bring it back to 0
        add(1, 3'b001, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b001, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(0, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);
        add(1, 3'b101, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b001, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);
        // pointer now 1: requester 0 must lose to requester 2
        add(1, 3'b101, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b100, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 1, 16'd0, 8'd0);
        add(1, 3'b000, 3'b000, 0, 8'd0,   7'd0,   3'd0, 3'b000, 0, 8'd0,   7'd0,   3'd0, 0, 16'd0, 8'd0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst_n, vt[i].req, vt[i].plot, vt[i].lane, vt[i].x, vt[i].y, vt[i].c);
            tick();
            chk($sformatf("v%0d.gnt", i),        32'(gnt),        32'(vt[i].e_gnt));
            chk($sformatf("v%0d.vga_plot", i),   32'(VGA_PLOT),   32'(vt[i].e_plot));
            chk($sformatf("v%0d.vga_x", i),      32'(VGA_X),      32'(vt[i].e_x));
            chk($sformatf("v%0d.vga_y", i),      32'(VGA_Y),      32'(vt[i].e_y));
            chk($sformatf("v%0d.vga_colour", i), 32'(VGA_COLOUR), 32'(vt[i].e_c));
            chk($sformatf("v%0d.busy", i),       32'(busy),       32'(vt[i].e_busy));
            chk($sformatf("v%0d.pix_count", i),  32'(pix_count),  32'(vt[i].e_pix));
            chk($sformatf("v%0d.clip_count", i), 32'(clip_count), 32'(vt[i].e_clip));
        end

        // round robin: all three request, each releases after one pixel
        drive(1'b0, 3'b000, 3'b000, 0, 8'd0, 7'd0, 3'd0);
        tick();
        req_h = 3'b111;
        for (int e = 0; e < 3; e++) begin
            oh = 3'b001 << e;
            drive(1'b1, req_h, 3'b000, 0, 8'd0, 7'd0, 3'd0);
            tick();
            chk($sformatf("rr%0d.gnt", e), 32'(gnt), 32'(oh));
            drive(1'b1, req_h, oh, e, 8'(10 + e), 7'(20 + e), 3'(e + 1));
            tick();
            chk($sformatf("rr%0d.vga_plot", e), 32'(VGA_PLOT), 32'd1);
            chk($sformatf("rr%0d.vga_x", e),    32'(VGA_X),    32'(10 + e));
            chk($sformatf("rr%0d.vga_y", e),    32'(VGA_Y),    32'(20 + e));
            chk($sformatf("rr%0d.held_gnt", e), 32'(gnt),      32'(oh));
            req_h = req_h & ~oh;
            drive(1'b1, req_h, 3'b000, 0, 8'd0, 7'd0, 3'd0);
            tick();
            chk($sformatf("rr%0d.gap_gnt", e),  32'(gnt),  32'd0);
            chk($sformatf("rr%0d.gap_busy", e), 32'(busy), 32'd1);
            drive(1'b1, req_h, 3'b000, 0, 8'd0, 7'd0, 3'd0);
            tick();
            chk($sformatf("rr%0d.idle_gnt", e),  32'(gnt),  32'd0);
            chk($sformatf("rr%0d.idle_busy", e), 32'(busy), 32'd0);
        end
        chk("rr.pix_count", 32'(pix_count), 32'd3);

        // clip counter saturates at 255
        drive(1'b0, 3'b000, 3'b000, 0, 8'd0, 7'd0, 3'd0);
        tick();
        drive(1'b1, 3'b001, 3'b000, 0, 8'd0, 7'd0, 3'd0);
        tick();
        for (int k = 0; k < 260; k++) begin
            drive(1'b1, 3'b001, 3'b001, 0, 8'd200, 7'd5, 3'd1);
            tick();
        end
        chk("sat.clip_count", 32'(clip_count), 32'd255);
        chk("sat.pix_count",  32'(pix_count),  32'd0);
        chk("sat.vga_plot",   32'(VGA_PLOT),   32'd0);
        chk("sat.vga_x",      32'(VGA_X),      32'd0);
        chk("sat.gnt",        32'(gnt),        32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
